// File: rtl/seg_dynamic_scan_if.sv
// Display-side bundle of the seven-segment scan driver: source data and controls in,
// digit select, segment bus and frame marker out.
interface seg_dynamic_scan_if #(
    parameter int DIGITS = 6
);
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   point;
    logic                en;
    logic                lz_blank;
    logic [DIGITS-1:0]   sel;
    logic [7:0]          seg;
    logic                frame;

    modport master (
        output data, point, en, lz_blank,
        input  sel, seg, frame
    );

    modport slave (
        input  data, point, en, lz_blank,
        output sel, seg, frame
    );
endinterface

// File: rtl/seg_dynamic_scan.sv
// Dynamic-scan driver for common-anode seven-segment displays: time-multiplexes hex
// digits over one segment bus with dp mask, leading-zero blanking and per-frame capture.
module seg_dynamic_scan #(
    parameter int          DIGITS   = 6,
    parameter logic [15:0] SCAN_MAX = 16'd49_999
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    seg_dynamic_scan_if.slave bus
);

    localparam int CNT_W = (SCAN_MAX == 16'd0) ? 1 : $clog2(int'(SCAN_MAX) + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_MAX);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Segment pattern g..a, active-low; dp is merged separately.
    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0: code = 7'h40;
            4'h1: code = 7'h79;
            4'h2: code = 7'h24;
            4'h3: code = 7'h30;
            4'h4: code = 7'h19;
            4'h5: code = 7'h12;
            4'h6: code = 7'h02;
            4'h7: code = 7'h78;
            4'h8: code = 7'h00;
            4'h9: code = 7'h10;
            4'hA: code = 7'h08;
            4'hB: code = 7'h03;
            4'hC: code = 7'h46;
            4'hD: code = 7'h21;
            4'hE: code = 7'h06;
            default: code = 7'h0e;
        endcase
        return code;
    endfunction

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_data_q, shadow_data_d;
    logic [DIGITS-1:0]   shadow_point_q, shadow_point_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic [7:0]          seg_q, seg_d;
    logic                frame_q, frame_d;

    logic                dwell_end;
    logic                snap;
    logic [DIGITS-1:0]   zero_from;
    logic                run_zero;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_zero;
    logic                blank;

    always_comb begin
        dwell_end = (cnt_q == CNT_LAST);
        snap      = dwell_end && (idx_q == IDX_LAST);

        cnt_d = dwell_end ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (dwell_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        shadow_data_d  = snap ? bus.data  : shadow_data_q;
        shadow_point_d = snap ? bus.point : shadow_point_q;
        frame_d        = snap;

        // zero_from[i] is set when nibbles i..DIGITS-1 of the snapshot are all zero.
        run_zero  = 1'b1;
        zero_from = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run_zero     = run_zero && (shadow_data_q[4*i +: 4] == 4'h0);
            zero_from[i] = run_zero;
        end

        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_zero = 1'b0;
        sel_d    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib  = shadow_data_q[4*i +: 4];
                cur_dp   = shadow_point_q[i];
                cur_zero = zero_from[i];
                sel_d[i] = bus.en;
            end
        end

        blank = bus.lz_blank && (idx_q != '0) && cur_zero;
        seg_d = 8'hff;
        if (bus.en) begin
            seg_d = {~cur_dp, blank ? 7'h7f : hex_seg(cur_nib)};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q          <= '0;
            idx_q          <= '0;
            shadow_data_q  <= '0;
            shadow_point_q <= '0;
            sel_q          <= '0;
            seg_q          <= 8'hff;
            frame_q        <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            shadow_data_q  <= shadow_data_d;
            shadow_point_q <= shadow_point_d;
            sel_q          <= sel_d;
            seg_q          <= seg_d;
            frame_q        <= frame_d;
        end
    end

    assign bus.sel   = sel_q;
    assign bus.seg   = seg_q;
    assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg_dynamic_scan.sv
// Directed bench for seg_dynamic_scan: a 6-digit/4-cycle build and a 1-digit/1-cycle build.
module tb_seg_dynamic_scan;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    seg_dynamic_scan_if #(.DIGITS(6)) b0 ();
    seg_dynamic_scan_if #(.DIGITS(1)) b1 ();

    seg_dynamic_scan #(.DIGITS(6), .SCAN_MAX(16'd3)) u_dut0 (
        .sys_clk (clk),
        .sys_rst (rst0),
        .bus     (b0)
    );

    seg_dynamic_scan #(.DIGITS(1), .SCAN_MAX(16'd0)) u_dut1 (
        .sys_clk (clk),
        .sys_rst (rst1),
        .bus     (b1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (b0.frame !== 1'b1 && n < 100);
        chk({tag, "_frame_seen"}, {31'd0, b0.frame}, 32'd1);
    endtask

    // Called on the frame-pulse cycle; checks one full frame and the next pulse.
    task automatic show_frame(input string tag, input logic [47:0] exp,
                              input int chg_digit, input logic [23:0] chg_data);
        for (int d = 0; d < 6; d++) begin
            @(negedge clk);
            chk({tag, "_sel"}, {26'd0, b0.sel}, 32'd1 << d);
            chk({tag, "_seg"}, {24'd0, b0.seg}, {24'd0, exp[8*d +: 8]});
            chk({tag, "_nofrm"}, {31'd0, b0.frame}, 32'd0);
            if (d == chg_digit) b0.data = chg_data;
            repeat (3) @(negedge clk);
        end
        chk({tag, "_frm"}, {31'd0, b0.frame}, 32'd1);
    endtask

    // Called on the cycle after the last reset edge with reset now released.
    task automatic post_reset_scan(input string tag);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk({tag, "_sel"}, {26'd0, b0.sel}, 32'd1 << k);
            chk({tag, "_seg"}, {24'd0, b0.seg}, 32'h0000_00c0);
            repeat (3) @(negedge clk);
        end
        chk({tag, "_frm"}, {31'd0, b0.frame}, 32'd1);
    endtask

    logic [3:0] vd [4];
    logic       vp [4];
    logic [7:0] es [6];

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        vd[0] = 4'h7; vp[0] = 1'b0;
        vd[1] = 4'hA; vp[1] = 1'b1;
        vd[2] = 4'h0; vp[2] = 1'b0;
        vd[3] = 4'hE; vp[3] = 1'b1;
        es[0] = 8'hc0; es[1] = 8'hc0; es[2] = 8'hf8;
        es[3] = 8'h08; es[4] = 8'hc0; es[5] = 8'h06;

        rst0 = 1'b1;
        rst1 = 1'b1;
        b0.data = '0; b0.point = '0; b0.en = 1'b1; b0.lz_blank = 1'b0;
        b1.data = '0; b1.point = '0; b1.en = 1'b1; b1.lz_blank = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_sel", {26'd0, b0.sel}, 32'd0);
        chk("rst_seg", {24'd0, b0.seg}, 32'h0000_00ff);
        chk("rst_frame", {31'd0, b0.frame}, 32'd0);
        chk("rst1_sel", {31'd0, b1.sel}, 32'd0);
        chk("rst1_seg", {24'd0, b1.seg}, 32'h0000_00ff);
        rst0 = 1'b0;
        post_reset_scan("init");
        @(negedge clk);
        chk("init_wrap_sel", {26'd0, b0.sel}, 32'd1);

        // decode and dp
        b0.data  = 24'h123456;
        b0.point = 6'b000100;
        wait_frame("dec");
        show_frame("dec", {8'hf9, 8'ha4, 8'hb0, 8'h19, 8'h92, 8'h82}, -1, 24'h0);

        // leading-zero blanking
        b0.data     = 24'h000405;
        b0.point    = 6'b000000;
        b0.lz_blank = 1'b1;
        wait_frame("lz");
        show_frame("lz", {8'hff, 8'hff, 8'hff, 8'h99, 8'hc0, 8'h92}, -1, 24'h0);
        b0.data = 24'h000000;
        wait_frame("lz0");
        show_frame("lz0", {8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hc0}, -1, 24'h0);
        b0.data     = 24'h000405;
        b0.lz_blank = 1'b0;
        wait_frame("nolz");
        show_frame("nolz", {8'hc0, 8'hc0, 8'hc0, 8'h99, 8'hc0, 8'h92}, -1, 24'h0);

        // frame coherence
        b0.data = 24'h111111;
        wait_frame("coh");
        show_frame("coh_old", {8'hf9, 8'hf9, 8'hf9, 8'hf9, 8'hf9, 8'hf9}, 2, 24'h222222);
        show_frame("coh_new", {8'ha4, 8'ha4, 8'ha4, 8'ha4, 8'ha4, 8'ha4}, -1, 24'h0);

        // enable drop while idx=3
        repeat (13) @(negedge clk);
        chk("en_pre_sel", {26'd0, b0.sel}, 32'd8);
        chk("en_pre_seg", {24'd0, b0.seg}, 32'h0000_00a4);
        b0.en = 1'b0;
        @(negedge clk);
        chk("en_off_sel", {26'd0, b0.sel}, 32'd0);
        chk("en_off_seg", {24'd0, b0.seg}, 32'h0000_00ff);
        repeat (4) @(negedge clk);
        chk("en_off2_sel", {26'd0, b0.sel}, 32'd0);
        b0.en = 1'b1;
        @(negedge clk);
        chk("en_on_sel", {26'd0, b0.sel}, 32'd16);
        chk("en_on_seg", {24'd0, b0.seg}, 32'h0000_00a4);
        repeat (4) @(negedge clk);
        chk("en_nofrm", {31'd0, b0.frame}, 32'd0);
        @(negedge clk);
        chk("en_frm", {31'd0, b0.frame}, 32'd1);

        // reset while idx=4
        b0.data = 24'h123456;
        repeat (17) @(negedge clk);
        chk("mrst_pre_sel", {26'd0, b0.sel}, 32'd16);
        rst0 = 1'b1;
        @(negedge clk);
        chk("mrst_sel", {26'd0, b0.sel}, 32'd0);
        chk("mrst_seg", {24'd0, b0.seg}, 32'h0000_00ff);
        chk("mrst_frame", {31'd0, b0.frame}, 32'd0);
        rst0 = 1'b0;
        post_reset_scan("mrst");
        @(negedge clk);
        chk("mrst_new_sel", {26'd0, b0.sel}, 32'd1);
        chk("mrst_new_seg", {24'd0, b0.seg}, 32'h0000_0082);

        // single-digit build, one-cycle dwell
        rst1 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("d1_sel", {31'd0, b1.sel}, 32'd1);
            chk("d1_frame", {31'd0, b1.frame}, 32'd1);
            chk("d1_seg", {24'd0, b1.seg}, {24'd0, es[k]});
            if (k < 4) begin
                b1.data  = vd[k];
                b1.point = vp[k];
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_dynamic_scan.md
# seg_dynamic_scan

Parametrised multi-digit dynamic-scan driver for common-anode seven-segment displays. Time-multiplexes up to 8 hex digits over one shared segment bus and adds a decimal-point mask, leading-zero blanking, a display enable and frame-coherent input capture. It sits between the data source (counter, measurement, or UART-decoded value) and the board's digit-select and segment pins, or the 595 shift-register front end.

## Interface
- DIGITS, 6, number of digits scanned; legal range 1..8.
- SCAN_MAX, 16'd49_999, dwell per digit minus 1, in sys_clk cycles (1 ms at 50 MHz).
- sys_clk  input  1  system clock; all logic on its rising edge.
- sys_rst  input  1  reset; one clock; reset is synchronous and active-high.
- data  input  4*DIGITS  hex nibbles; data[4i+3:4i] is digit i, digit 0 is rightmost/least significant.
- point  input  DIGITS  decimal-point mask; point[i]=1 lights dp of digit i.
- en  input  1  display enable; 0 blanks all outputs, scanning continues.
- lz_blank  input  1  1 enables leading-zero blanking.
- sel  output  DIGITS  one-hot digit select, active-high.
- seg  output  8  segment pattern, active-low; seg[7]=dp, seg[6:0]=g..a.
- frame  output  1  one-cycle pulse marking capture of a new data/point snapshot.

## Operation
- Dwell counter cnt: width clog2(SCAN_MAX+1). Counts 0..SCAN_MAX, then wraps to 0.
- Digit index idx: width max(1, clog2(DIGITS)). Advances on cnt==SCAN_MAX. Wraps DIGITS-1 -> 0. With DIGITS=1, idx stays 0.
- Snapshot: on cnt==SCAN_MAX && idx==DIGITS-1, registers shadow_data<=data and shadow_point<=point. frame is set in the same edge. Inputs are otherwise ignored, so there is no tearing within a frame.
- Hex decode of shadow nibble at idx uses the standard codes: 0 c0, 1 f9, 2 a4, 3 b0, 4 99, 5 92, 6 82, 7 f8, 8 80, 9 90, A 88, b 83, C c6, d a1, E 86, F 8e. The value is bit 7 of the code replaced by ~shadow_point[idx].
- Leading-zero blanking: with lz_blank=1, digit i>0 is blank when all shadow nibbles i..DIGITS-1 are 0.
  - Digit 0 is never blanked.
  - A blank digit drives seg[6:0]=7'h7f, with dp still governed by point.
  - sel stays asserted for a blank digit.
- lz_blank and en are sampled live each cycle, not snapshotted.
- en=0: sel=0 and seg=8'hff. cnt, idx, the snapshot logic and frame keep running.
- Reset (sys_rst=1 at a clock edge) has priority over everything, including mid-frame:
  - cnt=0, idx=0.
  - shadow_data=0, shadow_point=0.
  - sel=0, seg=8'hff, frame=0.

## Timing
- sel and seg are registered from idx, shadow and en. They change exactly 1 cycle after idx (or en) changes, and are always mutually aligned.
- Each digit is displayed for SCAN_MAX+1 cycles. One frame lasts DIGITS*(SCAN_MAX+1) cycles.
- frame rule: frame=1 for exactly one cycle; it equals the registered condition (cnt==SCAN_MAX && idx==DIGITS-1) and sits high during the cycle with idx=0 and the new shadow.
  - The first sel=1<<0 using new data appears the cycle after frame.
- First cycle after reset release: sel=1 (digit 0), seg=8'hc0 (shadow is 0), provided en=1.
- Live data from before the first frame pulse is not displayed.
- Simultaneous events: a data change on the snapshot cycle is captured (value present at that edge).
- en toggling on the snapshot cycle does not affect the capture.

## Test plan
Benches use DIGITS=6, SCAN_MAX=3 unless noted.

1. Reset behaviour: assert sys_rst for 2 cycles with en=1 -> sel=000000, seg=ff, frame=0 during reset. Next cycle sel=000001, seg=c0; sel advances every 4 cycles 000001->000010->...->100000->000001.
2. Decode and snapshot: data=24'h123456, point=6'b000100, lz_blank=0 -> after the first frame pulse sel/seg sequence is:
   - 000001/82, 000010/92, 000100/19 (4 with dp), 001000/b0, 010000/a4, 100000/f9.
   - frame pulses every 24 cycles.
3. Leading-zero blanking: data=24'h000405, point=0, lz_blank=1 -> digits 0..5 show 92, c0, 99, ff, ff, ff.
   - With data=0: digit0 c0, digits 1..5 ff.
   - With lz_blank=0: digits 3..5 show c0.
4. Frame coherence: change data from 24'h111111 to 24'h222222 while idx=2 -> the remaining digits of the current frame still show f9; all digits show a4 only after the next frame pulse.
5. Enable: drop en while idx=3 -> next cycle sel=0, seg=ff. Raise en 5 cycles later -> sel shows whatever digit idx now holds (scan timing undisturbed), and frame period is unchanged.
6. Reset mid-operation and DIGITS=1, SCAN_MAX=0:
   - Reset during idx=4 -> next cycle all state is cleared, and the first post-reset frame displays 0s.
   - DIGITS=1 build: sel held at 1, frame pulses every cycle, seg follows data[3:0] with 1-cycle snapshot plus 1-cycle output latency.
